// File: rtl/grasspopper_pkg.sv
// Shared types and constants for the grasspopper cipher-core arbiter.
// The optional counter feature is GRASSPOPPER_ARB_STATS_EN; this package is the same with or without it.
package grasspopper_pkg;

    localparam int CIPHER_BLOCK_W = 128;

    typedef logic [CIPHER_BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/grasspopper_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or after ptr, wrapping.
// Not affected by GRASSPOPPER_ARB_STATS_EN.
import grasspopper_pkg::*;

module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        // Scan from the farthest slot toward ptr so the nearest set request wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/grasspopper_arbiter.sv
// Round-robin arbiter that shares one grasspopper cipher core between N_CLIENTS requesters.
// Define GRASSPOPPER_ARB_STATS_EN to add per-client completed-block counters on cnt_o.
import grasspopper_pkg::*;

module grasspopper_arbiter #(
    parameter int N_CLIENTS = 4,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CLIENTS-1:0]       cli_req_i,
    input  block_t [N_CLIENTS-1:0]     cli_data_i,
    output logic [N_CLIENTS-1:0]       cli_gnt_o,
    output logic [N_CLIENTS-1:0]       cli_valid_o,
    output block_t                     cli_data_o,
    input  logic [N_CLIENTS-1:0]       cli_ack_i,
    output block_t                     core_data_o,
    output logic                       core_request_o,
    output logic                       core_ack_o,
    input  block_t                     core_data_i,
    input  logic                       core_valid_i,
    input  logic                       core_busy_i
`ifdef GRASSPOPPER_ARB_STATS_EN
    ,
    output logic [N_CLIENTS-1:0][CNT_W-1:0] cnt_o
`endif
);

    localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    arb_state_e           r_state;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        r_rr_ptr;
    logic [N_CLIENTS-1:0] r_gnt;
    logic [N_CLIENTS-1:0] r_valid;
    block_t               r_cli_data;
    block_t               r_core_data;
    logic                 r_core_req;
    logic                 r_core_ack;

    logic                 w_pick_valid;
    logic [IW-1:0]        w_pick_idx;
    logic                 w_release;

    rr_pick #(.N(N_CLIENTS), .IW(IW)) u_pick (
        .req   (cli_req_i),
        .ptr   (r_rr_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    assign w_release = (r_state == ST_RESP) && cli_ack_i[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_gnt       <= '0;
            r_valid     <= '0;
            r_cli_data  <= '0;
            r_core_data <= '0;
            r_core_req  <= 1'b0;
            r_core_ack  <= 1'b0;
        end else begin
            r_gnt      <= '0;
            r_core_req <= 1'b0;
            r_core_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid && !core_busy_i) begin
                        r_owner           <= w_pick_idx;
                        r_core_data       <= cli_data_i[w_pick_idx];
                        r_gnt[w_pick_idx] <= 1'b1;
                        r_rr_ptr          <= (w_pick_idx == IW'(N_CLIENTS - 1)) ? '0
                                                                               : w_pick_idx + 1'b1;
                        r_state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_core_req <= 1'b1;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_valid_i) begin
                        r_cli_data       <= core_data_i;
                        r_core_ack       <= 1'b1;
                        r_valid[r_owner] <= 1'b1;
                        r_state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_release) begin
                        r_valid <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef GRASSPOPPER_ARB_STATS_EN
    logic [N_CLIENTS-1:0][CNT_W-1:0] r_cnt;

    // Counts wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_release) begin
            r_cnt[r_owner] <= r_cnt[r_owner] + 1'b1;
        end
    end

    assign cnt_o = r_cnt;
`endif

    assign cli_gnt_o      = r_gnt;
    assign cli_valid_o    = r_valid;
    assign cli_data_o     = r_cli_data;
    assign core_data_o    = r_core_data;
    assign core_request_o = r_core_req;
    assign core_ack_o     = r_core_ack;

endmodule

// File: tb/tb_grasspopper_arbiter.sv
// Directed bench for grasspopper_arbiter with a behavioural stand-in for the cipher core.
// Define GRASSPOPPER_ARB_STATS_EN to also exercise the cnt_o counters (CNT_W=4).
import grasspopper_pkg::*;

module tb_grasspopper_arbiter;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     cli_req;
    block_t [N-1:0]   cli_data;
    logic [N-1:0]     cli_gnt_o;
    logic [N-1:0]     cli_valid_o;
    block_t           cli_data_o;
    logic [N-1:0]     cli_ack;
    block_t           core_data_o;
    logic             core_request_o;
    logic             core_ack_o;
    block_t           m_data;
    logic             m_valid;
    logic             m_busy;
    logic             force_busy;
    int               m_cnt;
    int               checks = 0;
    int               errors = 0;
`ifdef GRASSPOPPER_ARB_STATS_EN
    logic [N-1:0][CNT_W-1:0] cnt_o;
`endif

    grasspopper_arbiter #(.N_CLIENTS(N), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cli_req_i      (cli_req),
        .cli_data_i     (cli_data),
        .cli_gnt_o      (cli_gnt_o),
        .cli_valid_o    (cli_valid_o),
        .cli_data_o     (cli_data_o),
        .cli_ack_i      (cli_ack),
        .core_data_o    (core_data_o),
        .core_request_o (core_request_o),
        .core_ack_o     (core_ack_o),
        .core_data_i    (m_data),
        .core_valid_i   (m_valid),
        .core_busy_i    (m_busy | force_busy)
`ifdef GRASSPOPPER_ARB_STATS_EN
        ,
        .cnt_o          (cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference transform of the stand-in core.
    function automatic block_t cipher(input block_t x);
        return {x[63:0], x[127:64]} ^ 128'h0123456789abcdef_fedcba9876543210;
    endfunction

    // Stand-in core: fixed latency, holds valid until acked, shares rst.
    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_cnt   <= 0;
        end else if (core_request_o && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            m_data <= cipher(core_data_o);
        end else if (m_busy && !m_valid) begin
            if (m_cnt == 0) m_valid <= 1'b1;
            else            m_cnt   <= m_cnt - 1;
        end else if (m_valid && core_ack_o) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction for `owner`, from grant to release.
    task automatic serve(input int owner, input block_t blk, input logic [N-1:0] next_req,
                         input int delay, input bit stray);
        logic [N-1:0] oh;
        block_t       ct;
        oh = 4'(1) << owner;
        ct = cipher(blk);
        for (int i = 0; i < 20 && cli_gnt_o == '0; i++) tick();
        chk("gnt", cli_gnt_o, oh);
        chk("core_data", core_data_o, blk);
        cli_req = next_req;
        tick();
        chk("core_req", core_request_o, 1);
        chk("gnt_pulse", cli_gnt_o, 0);
        for (int i = 0; i < 30 && cli_valid_o == '0; i++) tick();
        chk("valid", cli_valid_o, oh);
        chk("data", cli_data_o, ct);
        chk("core_ack", core_ack_o, 1);
        for (int i = 0; i < delay; i++) begin
            cli_ack = (stray && i == 2) ? 4'b0010 : 4'b0000;
            tick();
            chk("hold_valid", cli_valid_o, oh);
            chk("hold_data", cli_data_o, ct);
            chk("no_gnt", cli_gnt_o, 0);
        end
        cli_ack = oh;
        tick();
        chk("release", cli_valid_o, 0);
        cli_ack = '0;
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        cli_req    = '0;
        cli_ack    = '0;
        force_busy = 1'b0;
        cli_data[0] = 128'hc177d2d35af6d17477545bfcf97d43a4;
        cli_data[1] = 128'h11111111_22222222_33333333_44444444;
        cli_data[2] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        cli_data[3] = 128'hffffffff_00000000_a5a5a5a5_5a5a5a5a;
        tick();
        tick();
        chk("rst_gnt", cli_gnt_o, 0);
        chk("rst_valid", cli_valid_o, 0);
        chk("rst_data", cli_data_o, 0);
        chk("rst_core_data", core_data_o, 0);
        chk("rst_core_req", core_request_o, 0);
        chk("rst_core_ack", core_ack_o, 0);
        rst = 1'b0;

        // Single client
        cli_req = 4'b0001;
        serve(0, cli_data[0], 4'b0000, 0, 1'b0);
        tick();
        chk("idle_core_data_hold", core_data_o, cli_data[0]);

        // Fairness from a fresh pointer
        rst_pulse();
        cli_req = 4'b1111;
        serve(0, cli_data[0], 4'b1111, 0, 1'b0);
        serve(1, cli_data[1], 4'b1111, 0, 1'b0);
        serve(2, cli_data[2], 4'b1111, 0, 1'b0);
        serve(3, cli_data[3], 4'b1111, 0, 1'b0);
        serve(0, cli_data[0], 4'b0000, 0, 1'b0);

        // Core busy holds off arbitration
        force_busy = 1'b1;
        cli_req    = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("busy_no_gnt", cli_gnt_o, 0);
        end
        force_busy = 1'b0;
        tick();
        chk("busy_fall_gnt", cli_gnt_o, 4'b0100);
        serve(2, cli_data[2], 4'b0000, 0, 1'b0);

        // Slow owner with a stray ack from client 1 and client 3 waiting
        cli_req = 4'b0001;
        serve(0, cli_data[0], 4'b1000, 10, 1'b1);
        serve(3, cli_data[3], 4'b0000, 0, 1'b0);

        // Reset during WAIT
        cli_req = 4'b0010;
        for (int i = 0; i < 20 && cli_gnt_o == '0; i++) tick();
        chk("rw_gnt", cli_gnt_o, 4'b0010);
        cli_req = '0;
        tick();
        tick();
        chk("rw_in_wait", dut.r_state, ST_WAIT);
        rst_pulse();
        chk("rw_gnt0", cli_gnt_o, 0);
        chk("rw_valid0", cli_valid_o, 0);
        chk("rw_data0", cli_data_o, 0);
        chk("rw_core_data0", core_data_o, 0);
        chk("rw_core_req0", core_request_o, 0);
        chk("rw_core_ack0", core_ack_o, 0);
        chk("rw_state", dut.r_state, ST_IDLE);
        chk("rw_ptr", dut.r_rr_ptr, 0);
        // Pointer back at 0 means client 0 beats client 2.
        cli_req = 4'b0101;
        serve(0, cli_data[0], 4'b0100, 0, 1'b0);
        serve(2, cli_data[2], 4'b0000, 0, 1'b0);

`ifdef GRASSPOPPER_ARB_STATS_EN
        rst_pulse();
        chk("cnt_rst", cnt_o, 0);
        for (int n = 0; n < 17; n++) begin
            cli_data[3] = {96'h0, 32'(n)} ^ 128'h3333_0000_0000_0000_0000_0000_0000_0000;
            cli_req     = 4'b1000;
            serve(3, cli_data[3], 4'b0000, 0, 1'b0);
        end
        chk("cnt3_wrap", cnt_o[3], 1);
        chk("cnt0", cnt_o[0], 0);
        chk("cnt1", cnt_o[1], 0);
        chk("cnt2", cnt_o[2], 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grasspopper_arbiter.md
# grasspopper_arbiter

Round-robin arbiter that shares one `grasspopper` cipher core between `N_CLIENTS` requesters. It sits directly in front of the core and owns its `request_i`/`ack_i` handshake. It accepts one 128-bit block at a time from the winning client, sequences the core through a full encryption, and returns the ciphertext to that client. It then holds the ciphertext until the client acknowledges it.

## Interface
- `N_CLIENTS`, 4, number of requesters (2..8)
- `CNT_W`, 16, width of per-client statistics counters (used only with stats enabled)

- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `cli_req_i` in N_CLIENTS: client i has a block pending; level, sampled only in IDLE
- `cli_data_i` in N_CLIENTS×128: plaintext per client, must be stable while `cli_req_i[i]` is high
- `cli_gnt_o` out N_CLIENTS: one-cycle pulse, block of client i accepted
- `cli_valid_o` out N_CLIENTS: one-hot, ciphertext for client i is on `cli_data_o`
- `cli_data_o` out 128: ciphertext, shared by all clients
- `cli_ack_i` in N_CLIENTS: client i consumed its result
- `core_data_o` out 128: to core `data_i`
- `core_request_o` out 1: to core `request_i`
- `core_ack_o` out 1: to core `ack_i`
- `core_data_i` in 128: from core `data_o`
- `core_valid_i` in 1: from core `valid_o`
- `core_busy_i` in 1: from core `busy_o`
- `cnt_o` out N_CLIENTS×CNT_W: completed blocks per client (exists only with `GRASSPOPPER_ARB_STATS_EN`)

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Arbitration happens only when `|cli_req_i && !core_busy_i`.
  - The winner is the first set request at or after `rr_ptr`, searching upward and wrapping.
  - On a win: latch winner index into `owner`, latch `cli_data_i[owner]` into `core_data_o`, pulse `cli_gnt_o[owner]`, set `rr_ptr <= owner+1` (mod N_CLIENTS), go to ISSUE.
- **ISSUE**: `core_request_o`=1 for exactly one cycle, then go to WAIT.
- **WAIT**: when `core_valid_i`=1, capture `core_data_i` into `cli_data_o`, pulse `core_ack_o` for one cycle, go to RESP.
- **RESP**: `cli_valid_o[owner]`=1 until `cli_ack_i[owner]`=1, then go to IDLE.
- A request withdrawn before it is granted is dropped silently.
- A request still high after its grant counts as a new request. Round-robin order guarantees that other pending clients are served first.
- The arbiter ignores `cli_ack_i` from any client that is not the owner, and ignores `core_valid_i` in every state except WAIT.
- `core_data_o` holds the last latched value between transactions.
- Reset is allowed at any time, including mid-operation. It returns the FSM to IDLE.
  - All outputs reset to 0.
  - `rr_ptr` resets to 0, and all counters reset to 0.
  - The core shares `rst`, so no partial transaction survives.

## Timing
- All outputs are registered.
- Grant at cycle T, then `core_request_o` at T+1, then WAIT from T+2.
- `core_valid_i` sampled at edge V leads to `core_ack_o` and `cli_valid_o[owner]` being high in cycle V+1.
- Client ack sampled at edge A leads to IDLE at A+1. The earliest next grant is A+1.
- Minimum arbiter overhead is 4 cycles per block plus the core latency.
- Exactly one transaction is in flight; there is no pipelining.

## Configuration
- `GRASSPOPPER_ARB_STATS_EN` defined:
  - Adds `cnt_o`, with one counter per client.
  - A counter increments at the cycle the RESP→IDLE transition is taken for that owner.
  - Counters wrap at 2^CNT_W.
- `GRASSPOPPER_ARB_STATS_EN` undefined: no counters and no `cnt_o` port. Behaviour is otherwise identical.

## Structure
- Package `grasspopper_pkg` holds:
  - the `block_t` typedef (`logic [127:0]`)
  - the `arb_state_e` enum
  - the `CIPHER_BLOCK_W`=128 constant
- Sub-module `rr_pick`: combinational round-robin priority encoder with inputs `req`, `ptr` and outputs `valid`, `idx`.

## Test plan
- **Single client**: client 0 sends 128'hc177d2d35af6d17477545bfcf97d43a4.
  - Required: one `cli_gnt_o[0]` pulse, then `core_request_o` 1 cycle later, then `cli_data_o` equals the core reference ciphertext while `cli_valid_o`=4'b0001.
- **Fairness**: all 4 clients hold `cli_req_i` high with distinct blocks.
  - Required: grant order 0,1,2,3,0; each result is routed only to its owner.
- **Core busy**: force `core_busy_i`=1 with `cli_req_i`=4'b0100.
  - Required: no grant while busy; grant to client 2 in the cycle after busy falls.
- **Slow client**: owner delays `cli_ack_i` 10 cycles.
  - Required: `cli_valid_o` and `cli_data_o` stay stable for all 10 cycles; no new grant; a stray `cli_ack_i[1]` during the delay is ignored.
- **Reset mid-WAIT**: assert `rst` one cycle during WAIT.
  - Required: all outputs 0 next cycle, FSM in IDLE, `rr_ptr`=0; the next request is served normally.
- **Stats**: with `GRASSPOPPER_ARB_STATS_EN` and `CNT_W`=4, run 17 blocks on client 3.
  - Required: `cnt_o[3]`=1 (wrapped), other counters 0.
